// File: rtl/ahb3lite_apb_bridge.sv
// AHB3-Lite slave to APB master bridge on a single clock. Each accepted AHB
// transfer becomes one APB setup/access pair; APB errors become AHB ERROR.
module ahb3lite_apb_bridge #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 10
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [HADDR_SIZE-1:0]   HADDR,
  input  logic [HDATA_SIZE-1:0]   HWDATA,
  output logic [HDATA_SIZE-1:0]   HRDATA,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [1:0]              HTRANS,
  input  logic                    HMASTLOCK,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [2:0]              PPROT,
  output logic                    PWRITE,
  output logic [HDATA_SIZE/8-1:0] PSTRB,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic [HDATA_SIZE-1:0]   PWDATA,
  input  logic [HDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int         STRB_W   = HDATA_SIZE / 8;
  localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WLATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   size_ok;
  logic   take;
  logic   unused_sig;

  assign accept     = HSEL & HREADY & HTRANS[1];
  assign size_ok    = (HSIZE <= SIZE_MAX);
  assign unused_sig = ^{HBURST, HMASTLOCK, HPROT[3:2]};

  // Contiguous 2^size byte lanes starting at the size-aligned lane offset.
  function automatic logic [STRB_W-1:0] strb_gen(input logic [HADDR_SIZE-1:0] addr,
                                                 input logic [2:0]            size);
    logic [STRB_W-1:0] strb;
    int nbytes;
    int base;
    nbytes = 1 << size;
    base   = int'(addr & HADDR_SIZE'(STRB_W - 1)) & ~(nbytes - 1);
    for (int i = 0; i < STRB_W; i++) begin
      strb[i] = (i >= base) && (i < base + nbytes);
    end
    return strb;
  endfunction

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (!accept) begin
          state_nxt = ST_IDLE;
        end else if (!size_ok) begin
          state_nxt = ST_ERR1;
        end else begin
          take      = 1'b1;
          state_nxt = HWRITE ? ST_WLATCH : ST_SETUP;
        end
      end
      ST_WLATCH: state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) state_nxt = PSLVERR ? ST_ERR1 : ST_DONE;
      end
      ST_ERR1:   state_nxt = ST_ERR2;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PPROT     <= '0;
      PSTRB     <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      PSEL      <= (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
      PENABLE   <= (state_nxt == ST_ACCESS);
      HREADYOUT <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE) ||
                   (state_nxt == ST_ERR2);
      HRESP     <= (state_nxt == ST_ERR1) || (state_nxt == ST_ERR2);
      if (take) begin
        PADDR  <= HADDR[PADDR_SIZE-1:0];
        PWRITE <= HWRITE;
        PPROT  <= {~HPROT[0], 1'b1, HPROT[1]};
        PSTRB  <= HWRITE ? strb_gen(HADDR, HSIZE) : '0;
      end
      if (state == ST_WLATCH) PWDATA <= HWDATA;
      if ((state == ST_ACCESS) && PREADY && !PWRITE) HRDATA <= PRDATA;
    end
  end

endmodule

// File: doc/ahb3lite_apb_bridge.md
Name: ahb3lite_apb_bridge

Overview:
Single-clock bridge from AHB3-Lite to APB. It is an AHB3-Lite slave on the system bus and the APB master for one peripheral segment. APB runs on HCLK, so there is no clock-domain crossing. Each AHB transfer is converted into exactly one APB setup/access sequence, with wait states inserted through HREADYOUT and APB errors mapped to the two-cycle AHB ERROR response.

Parameters:
HADDR_SIZE, 32, AHB address width
HDATA_SIZE, 32, AHB and APB data width (PDATA_SIZE equals HDATA_SIZE); 8, 16, 32 or 64
PADDR_SIZE, 10, APB address width; must be ≤ HADDR_SIZE

Ports:
HCLK  in  1  clock, shared by AHB and APB
HRESETn  in  1  synchronous reset, active low
HSEL  in  1  slave select
HADDR  in  HADDR_SIZE  address
HWDATA  in  HDATA_SIZE  write data, valid in data phase
HRDATA  out  HDATA_SIZE  read data
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size
HBURST  in  3  ignored
HPROT  in  4  protection
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
HMASTLOCK  in  1  ignored
HREADY  in  1  bus-level ready
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PPROT  out  3  APB protection
PWRITE  out  1  APB direction
PSTRB  out  HDATA_SIZE/8  write byte strobes
PADDR  out  PADDR_SIZE  APB address
PWDATA  out  HDATA_SIZE  APB write data
PRDATA  in  HDATA_SIZE  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- One clock, HCLK. Reset is synchronous and active low (HRESETn sampled on the HCLK rising edge). The same clock and reset drive the APB side.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PPROT=0, PSTRB=0, PADDR=0, PWDATA=0, FSM=IDLE.
- All outputs are registered.
- Address phase is accepted when HSEL & HREADY & HTRANS[1]=1 (NONSEQ or SEQ).
  - On acceptance, latch HADDR, HWRITE, HSIZE and HPROT.
  - IDLE and BUSY transfers get a zero-wait OKAY response.
- FSM states: IDLE, WLATCH, SETUP, ACCESS, DONE, ERR1, ERR2.
  - IDLE: HREADYOUT=1. Accepted write → WLATCH. Accepted read → SETUP. Illegal HSIZE (>log2(HDATA_SIZE/8)) → ERR1 with no APB activity.
  - WLATCH: HREADYOUT=0. Register HWDATA into PWDATA → SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0 → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, holds while PREADY=0. On PREADY=1: register PRDATA into HRDATA, drop PSEL and PENABLE. PSLVERR=0 → DONE; PSLVERR=1 → ERR1.
  - DONE: HREADYOUT=1, HRESP=0. Acceptance is evaluated as in IDLE, so back-to-back transfers proceed directly to WLATCH/SETUP/ERR1; otherwise → IDLE.
  - ERR1: HRESP=1, HREADYOUT=0 → ERR2.
  - ERR2: HRESP=1, HREADYOUT=1. Acceptance evaluated as in IDLE.
- Latency with PREADY tied to 1: read data phase = 3 cycles (2 wait states); write data phase = 4 cycles (3 wait states). Each PREADY=0 cycle adds one cycle.
- Address and control mapping:
  - PADDR = latched HADDR[PADDR_SIZE-1:0].
  - PWRITE = latched HWRITE.
  - PPROT[0] = HPROT[1]; PPROT[1] = 1 (non-secure); PPROT[2] = ~HPROT[0].
- PSTRB:
  - Reads: all zeros.
  - Writes: a contiguous block of 2^HSIZE ones, starting at byte lane HADDR[log2(HDATA_SIZE/8)-1:0], aligned down to 2^HSIZE.
  - Example at 32 bits: byte at addr 0x3 → 4'b1000; halfword at 0x2 → 4'b1100; word → 4'b1111.
- HRDATA holds its last value outside completed reads.
- HSEL/HTRANS are not sampled while HREADY=0; those transfers are ignored.
- Reset mid-operation: the next edge with HRESETn=0 forces all reset values. PSEL drops immediately and no AHB response is completed.
- PSLVERR is only observed when PSEL & PENABLE & PREADY.

Test Plan:
- Reset: hold HRESETn=0 for 3 edges, mid-ACCESS → next cycle PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0, HRDATA=0.
- Single word write, addr 0x104, data 0xDEADBEEF, PREADY=1 → PADDR=0x104, PWDATA=0xDEADBEEF, PSTRB=4'hF, PPROT=3'b010 for HPROT=4'b0001; HREADYOUT low exactly 3 cycles; OKAY.
- Byte write to 0x3, then halfword write to 0x2 → PSTRB 4'b1000, then 4'b1100; one SETUP+ACCESS pair each.
- Read from 0x20 with PREADY low for 4 cycles, PRDATA=0x12345678 → PENABLE high 5 cycles; HRDATA=0x12345678 when HREADYOUT returns high.
- Read with PSLVERR=1 at completion → HRESP=1 for 2 cycles, HREADYOUT 0 then 1. An HSIZE=3 transfer on the 32-bit bus → same ERROR response, PSEL never asserted.
- Back-to-back NONSEQ write, read, IDLE, BUSY, PREADY=1 → second SETUP starts the cycle after DONE; IDLE/BUSY get OKAY with HREADYOUT=1 and no PSEL.
